controlador_matriz: RTL and testbench

- Owns the timing and content of the 5-column × 7-row LED matrix.
- Generates the column-scan counter and the matrix `enable`.
- Holds a double-buffered frame: game logic writes columns into a shadow buffer, and a commit copies the shadow buffer to the displayed maps only at a frame boundary, so the display never tears.
- Drives `contador`, `enable` and `mapa0..mapa4` of `matriz_leds` directly, replacing hard-wired maps and the free-running counter.

---
 rtl/controlador_matriz_pkg.sv | 7 +
 rtl/divisor_tick.sv | 22 ++
 rtl/controlador_matriz.sv | 105 ++++++++++
 tb/tb_controlador_matriz.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/controlador_matriz_pkg.sv
// Shared matrix geometry for controlador_matriz and matriz_leds.
package matriz_defs;
    localparam int         NUM_COLS = 5;
    localparam int         NUM_ROWS = 7;
    localparam int         COL_W    = 3;
    localparam logic [2:0] LAST_COL = 3'd4;
endpackage

// File: rtl/divisor_tick.sv
// Prescaler: counts 0..DIV-1 and raises a single-cycle tick on the last count.
module divisor_tick #(
    parameter int DIV = 65536
) (
    input  logic clock_in,
    input  logic reset,
    output logic tick
);
    localparam int           W    = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] presc;

    // Free-running prescaler, wraps after DIV-1.
    always_ff @(posedge clock_in) begin
        if (reset)             presc <= '0;
        else if (presc == LAST) presc <= '0;
        else                   presc <= presc + 1'b1;
    end

    assign tick = (presc == LAST);
endmodule

// File: rtl/controlador_matriz.sv
// LED matrix controller: column scan, double-buffered column maps, commit at
// frame boundary. Optional blinking is compiled in with CONTROLADOR_MATRIZ_BLINK_EN.
module controlador_matriz
    import matriz_defs::*;
#(
    parameter int DIV          = 65536,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clock_in,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [COL_W-1:0]    wr_col,
    input  logic [NUM_ROWS-1:0] wr_data,
    input  logic                commit,
    input  logic                blink,
    output logic [COL_W-1:0]    contador,
    output logic                enable,
    output logic [NUM_ROWS-1:0] mapa0,
    output logic [NUM_ROWS-1:0] mapa1,
    output logic [NUM_ROWS-1:0] mapa2,
    output logic [NUM_ROWS-1:0] mapa3,
    output logic [NUM_ROWS-1:0] mapa4,
    output logic                swap_pending,
    output logic                frame_done
);
    logic                tick;
    logic                frame_end;
    logic [NUM_ROWS-1:0] shadow [NUM_COLS];
    logic [NUM_ROWS-1:0] active [NUM_COLS];

    divisor_tick #(.DIV(DIV)) u_divisor_tick (
        .clock_in (clock_in),
        .reset    (reset),
        .tick     (tick)
    );

    assign frame_end = tick && (contador == LAST_COL);

    // Column scan counter, steps 0..4 once per tick.
    always_ff @(posedge clock_in) begin
        if (reset)                 contador <= '0;
        else if (frame_end)        contador <= '0;
        else if (tick)             contador <= contador + 1'b1;
    end

    // Shadow buffer writes; out-of-range columns are dropped.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            for (int i = 0; i < NUM_COLS; i++) shadow[i] <= '0;
        end else if (wr_en && (wr_col <= LAST_COL)) begin
            shadow[wr_col] <= wr_data;
        end
    end

    // Commit flag: a commit coinciding with frame_end re-arms for the next frame.
    always_ff @(posedge clock_in) begin
        if (reset) swap_pending <= 1'b0;
        else       swap_pending <= commit | (swap_pending & ~frame_end);
    end

    // Displayed maps: copied from pre-edge shadow only on a pending frame end.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            for (int i = 0; i < NUM_COLS; i++) active[i] <= '0;
        end else if (frame_end && swap_pending) begin
            for (int i = 0; i < NUM_COLS; i++) active[i] <= shadow[i];
        end
    end

    // Registered frame-start pulse, high after contador wraps 4->0.
    always_ff @(posedge clock_in) begin
        if (reset) frame_done <= 1'b0;
        else       frame_done <= frame_end;
    end

    assign mapa0 = active[0];
    assign mapa1 = active[1];
    assign mapa2 = active[2];
    assign mapa3 = active[3];
    assign mapa4 = active[4];

`ifdef CONTROLADOR_MATRIZ_BLINK_EN
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
    logic [7:0] blink_cnt;

    // Blink: enable toggles every BLINK_FRAMES frames, only on frame_end.
    always_ff @(posedge clock_in) begin
        if (reset || !blink) begin
            blink_cnt <= '0;
            enable    <= 1'b1;
        end else if (frame_end) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                enable    <= ~enable;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = blink & (BLINK_FRAMES > 0);
    assign enable     = 1'b1;
`endif
endmodule

// File: tb/tb_controlador_matriz.sv
// Directed bench for controlador_matriz with DIV=4, BLINK_FRAMES=2.
module tb_controlador_matriz;
    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_col;
    logic [6:0] wr_data;
    logic       commit;
    logic       blink;
    logic [2:0] contador;
    logic       enable;
    logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
    logic       swap_pending;
    logic       frame_done;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;  // edges since last reset release

    controlador_matriz #(.DIV(4), .BLINK_FRAMES(2)) dut (
        .clock_in     (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_col       (wr_col),
        .wr_data      (wr_data),
        .commit       (commit),
        .blink        (blink),
        .contador     (contador),
        .enable       (enable),
        .mapa0        (mapa0),
        .mapa1        (mapa1),
        .mapa2        (mapa2),
        .mapa3        (mapa3),
        .mapa4        (mapa4),
        .swap_pending (swap_pending),
        .frame_done   (frame_done)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic wr(input logic [2:0] col, input logic [6:0] data);
        wr_en = 1'b1; wr_col = col; wr_data = data;
        step();
        wr_en = 1'b0; wr_col = '0; wr_data = '0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    task automatic check_maps(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3, input logic [6:0] e4);
        check({tag, "_mapa0"}, 32'(mapa0), 32'(e0));
        check({tag, "_mapa1"}, 32'(mapa1), 32'(e1));
        check({tag, "_mapa2"}, 32'(mapa2), 32'(e2));
        check({tag, "_mapa3"}, 32'(mapa3), 32'(e3));
        check({tag, "_mapa4"}, 32'(mapa4), 32'(e4));
    endtask

`ifdef CONTROLADOR_MATRIZ_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_col = '0; wr_data = '0; commit = 1'b0; blink = 1'b0;

        // Reset for 3 edges, then release.
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        check("rst_contador", 32'(contador), 32'd0);
        check("rst_enable", 32'(enable), 32'd1);
        check("rst_swap_pending", 32'(swap_pending), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check_maps("rst", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);

        // First frame: column scan, frame pulse, basic swap.
        // Writes sampled at edges 1..5, commit sampled at edge 6.
        for (int c = 0; c < 24; c++) begin
            wr_en   = (cyc < 5);
            wr_col  = 3'(cyc);
            wr_data = (cyc < 5) ? 7'(1 << cyc) : 7'h00;
            commit  = (cyc == 5);
            step();
            check("scan_contador", 32'(contador), 32'((cyc / 4) % 5));
            check("scan_frame_done", 32'(frame_done), 32'(cyc == 20));
            check("scan_swap_pending", 32'(swap_pending), 32'(cyc >= 6 && cyc < 20));
            check("scan_mapa0", 32'(mapa0), (cyc >= 20) ? 32'h01 : 32'h00);
            check("scan_mapa4", 32'(mapa4), (cyc >= 20) ? 32'h10 : 32'h00);
        end
        wr_en = 1'b0; wr_col = '0; wr_data = '0; commit = 1'b0;
        check_maps("basic", 7'h01, 7'h02, 7'h04, 7'h08, 7'h10);

        // Boundary collision: write + commit on the frame_end cycle (edge 40).
        wr(3'd2, 7'h55);
        pulse_commit();
        run_to(39);
        check("coll_pre_mapa2", 32'(mapa2), 32'h04);
        wr_en = 1'b1; wr_col = 3'd2; wr_data = 7'h7F; commit = 1'b1;
        step();
        wr_en = 1'b0; wr_col = '0; wr_data = '0; commit = 1'b0;
        check("coll_contador", 32'(contador), 32'd0);
        check("coll_frame_done", 32'(frame_done), 32'd1);
        check("coll_swap_pending", 32'(swap_pending), 32'd1);
        check_maps("coll", 7'h01, 7'h02, 7'h55, 7'h08, 7'h10);
        run_to(59);
        check("coll_hold_mapa2", 32'(mapa2), 32'h55);
        check("coll_hold_pending", 32'(swap_pending), 32'd1);
        step();
        check("coll_next_mapa2", 32'(mapa2), 32'h7F);
        check("coll_next_pending", 32'(swap_pending), 32'd0);

        // Out-of-range writes and double commit.
        wr(3'd5, 7'h11);
        wr(3'd6, 7'h22);
        wr(3'd7, 7'h66);
        wr(3'd0, 7'h33);
        pulse_commit();
        run_to(71);
        pulse_commit();
        check("dbl_pending", 32'(swap_pending), 32'd1);
        check_maps("dbl_before", 7'h01, 7'h02, 7'h7F, 7'h08, 7'h10);
        run_to(80);
        check("dbl_pending_clear", 32'(swap_pending), 32'd0);
        check_maps("dbl_after", 7'h33, 7'h02, 7'h7F, 7'h08, 7'h10);
        run_to(100);
        check("dbl_no_rearm", 32'(swap_pending), 32'd0);
        check_maps("dbl_stable", 7'h33, 7'h02, 7'h7F, 7'h08, 7'h10);

        // Reset while a commit is pending.
        wr(3'd1, 7'h44);
        pulse_commit();
        run_to(110);
        check("rmp_pending_before", 32'(swap_pending), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cyc   = 0;
        check("rmp_pending", 32'(swap_pending), 32'd0);
        check("rmp_contador", 32'(contador), 32'd0);
        check_maps("rmp_rst", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
        for (int c = 0; c < 40; c++) begin
            step();
            check("rmp_hold_pending", 32'(swap_pending), 32'd0);
            check("rmp_hold_mapa1", 32'(mapa1), 32'h00);
        end
        check_maps("rmp_end", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
        check("rmp_contador_end", 32'(contador), 32'd0);

        // Blink: frame ends at edges 60, 80, 100, 120...; enable toggles at 80, 120, 160.
        blink = 1'b1;
        run_to(60);
        check("blink_60", 32'(enable), 32'd1);
        run_to(79);
        check("blink_79", 32'(enable), 32'd1);
        step();
        check("blink_80", 32'(enable), BLINK_ON ? 32'd0 : 32'd1);
        run_to(119);
        check("blink_119", 32'(enable), BLINK_ON ? 32'd0 : 32'd1);
        step();
        check("blink_120", 32'(enable), 32'd1);
        run_to(160);
        check("blink_160", 32'(enable), BLINK_ON ? 32'd0 : 32'd1);
        run_to(165);
        blink = 1'b0;
        step();
        check("blink_off", 32'(enable), 32'd1);
        run_to(200);
        check("blink_off_hold", 32'(enable), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
